// File: rtl/ysyx_23060072_wbu_if.sv
// ysyx_23060072_wbu_if: bus bundle of the write-back unit
// Carries ALU/LSU write-back, load issue, the two register read ports, stall, busy, commit record and error.
// slave modport is the write-back unit side; master modport is the pipeline side driving it.
interface ysyx_23060072_wbu_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic          alu_wb_valid_i;
    logic [AW-1:0] alu_wb_rd_i;
    logic [DW-1:0] alu_wb_data_i;
    logic          load_issue_i;
    logic [AW-1:0] load_rd_i;
    logic          LSU_wb_flag_i;
    logic [DW-1:0] LSU_wb_data_i;
    logic [AW-1:0] rs1_addr_i;
    logic [AW-1:0] rs2_addr_i;
    logic [DW-1:0] rs1_data_o;
    logic [DW-1:0] rs2_data_o;
    logic          load_use_stall_o;
    logic          wb_busy_o;
    logic          commit_valid_o;
    logic [AW-1:0] commit_rd_o;
    logic [DW-1:0] commit_data_o;
    logic          err_o;
    modport slave (
        input  alu_wb_valid_i, alu_wb_rd_i, alu_wb_data_i, load_issue_i, load_rd_i,
               LSU_wb_flag_i, LSU_wb_data_i, rs1_addr_i, rs2_addr_i,
        output rs1_data_o, rs2_data_o, load_use_stall_o, wb_busy_o,
               commit_valid_o, commit_rd_o, commit_data_o, err_o
    );
    modport master (
        output alu_wb_valid_i, alu_wb_rd_i, alu_wb_data_i, load_issue_i, load_rd_i,
               LSU_wb_flag_i, LSU_wb_data_i, rs1_addr_i, rs2_addr_i,
        input  rs1_data_o, rs2_data_o, load_use_stall_o, wb_busy_o,
               commit_valid_o, commit_rd_o, commit_data_o, err_o
    );
endinterface

// File: rtl/ysyx_23060072_wbu.sv
// ysyx_23060072_wbu: RV32E write-back unit with register file, load tracker, ALU skid buffer and commit record
// Ports: clk, rst_n (async active-low), bus (ysyx_23060072_wbu_if.slave: ALU/LSU write-back, load issue,
// rs1/rs2 read ports, load_use_stall_o, wb_busy_o, commit_*_o, err_o).
// YSYX_23060072_WBU_BYPASS_EN: defined = same-cycle write forwarding to read ports; undefined = array-only reads
// with the stall widened to cover the skid entry.
module ysyx_23060072_wbu #(
    parameter int NREG         = 16,
    parameter int AW           = 4,
    parameter int DW           = 32,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    ysyx_23060072_wbu_if.slave bus
);
    localparam int CW = $clog2(LOAD_TIMEOUT + 1);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] regs [NREG];
    logic          skid_v;
    logic [AW-1:0] skid_rd;
    logic [DW-1:0] skid_data;
    logic          lsu_we, timeout, alu_ok, skid_load, we, err_set, dep_ld;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          commit_valid, err;
    logic [AW-1:0] commit_rd;
    logic [DW-1:0] commit_data;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else state <= state_nxt;
    always_comb
        state_nxt = (state == S_IDLE) ? (bus.load_issue_i ? S_WAIT : S_IDLE)
                                      : ((bus.LSU_wb_flag_i || timeout) ? S_IDLE : S_WAIT);
    always_comb begin
        lsu_we    = state == S_WAIT && bus.LSU_wb_flag_i;
        timeout   = state == S_WAIT && !bus.LSU_wb_flag_i && cnt == CW'(LOAD_TIMEOUT - 1);
        alu_ok    = bus.alu_wb_valid_i && !skid_v;
        // a same-rd ALU entry is older than the load, so it is dropped rather than skidded
        skid_load = lsu_we && alu_ok && bus.alu_wb_rd_i != ld_rd;
        we        = lsu_we || skid_v || alu_ok;
        wa        = lsu_we ? ld_rd : skid_v ? skid_rd : bus.alu_wb_rd_i;
        wd        = lsu_we ? bus.LSU_wb_data_i : skid_v ? skid_data : bus.alu_wb_data_i;
        err_set   = (state == S_WAIT && bus.load_issue_i) || (state == S_IDLE && bus.LSU_wb_flag_i)
                    || timeout || (bus.alu_wb_valid_i && skid_v);
        dep_ld    = state == S_WAIT && ld_rd != '0 && (bus.rs1_addr_i == ld_rd || bus.rs2_addr_i == ld_rd);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt   <= '0;
            ld_rd <= '0;
        end else if (state == S_IDLE && bus.load_issue_i) begin
            cnt   <= '0;
            ld_rd <= bus.load_rd_i;
        end else if (state == S_WAIT) begin
            cnt <= cnt + 1'b1;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            skid_v    <= 1'b0;
            skid_rd   <= '0;
            skid_data <= '0;
        end else if (skid_load) begin
            skid_v    <= 1'b1;
            skid_rd   <= bus.alu_wb_rd_i;
            skid_data <= bus.alu_wb_data_i;
        end else if (skid_v && !lsu_we) begin
            skid_v <= 1'b0;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_data  <= '0;
            err          <= 1'b0;
        end else begin
            commit_valid <= we;
            if (we) begin
                commit_rd   <= wa;
                commit_data <= (wa == '0) ? '0 : wd;
            end
            if (err_set) err <= 1'b1;
        end
`ifdef YSYX_23060072_WBU_BYPASS_EN
    assign bus.rs1_data_o = (bus.rs1_addr_i == '0) ? '0 : (we && wa == bus.rs1_addr_i) ? wd : regs[bus.rs1_addr_i];
    assign bus.rs2_data_o = (bus.rs2_addr_i == '0) ? '0 : (we && wa == bus.rs2_addr_i) ? wd : regs[bus.rs2_addr_i];
    assign bus.load_use_stall_o = dep_ld;
`else
    // x0 is never written, so the array alone already reads 0 there
    assign bus.rs1_data_o = regs[bus.rs1_addr_i];
    assign bus.rs2_data_o = regs[bus.rs2_addr_i];
    assign bus.load_use_stall_o = dep_ld || (skid_v && (skid_rd == bus.rs1_addr_i || skid_rd == bus.rs2_addr_i));
`endif
    assign bus.wb_busy_o      = skid_v;
    assign bus.commit_valid_o = commit_valid;
    assign bus.commit_rd_o    = commit_rd;
    assign bus.commit_data_o  = commit_data;
    assign bus.err_o          = err;
endmodule

// File: tb/tb_ysyx_23060072_wbu.sv
// tb_ysyx_23060072_wbu: directed plus random bench for the write-back unit against a queue-based reference model
module tb_ysyx_23060072_wbu;
    localparam int AW = 4, DW = 32, LT = 15;
`ifdef YSYX_23060072_WBU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct packed {logic [3:0] rd; logic [31:0] d;} ent_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    ysyx_23060072_wbu_if #(.AW(AW), .DW(DW)) bus ();
    ysyx_23060072_wbu #(.NREG(16), .AW(AW), .DW(DW), .LOAD_TIMEOUT(LT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic [31:0] m_reg [16];
    bit          m_pend, m_err;
    logic [3:0]  m_prd;
    int          m_wcnt;
    ent_t        skq[$];
    int          n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic drv(input bit av, input logic [3:0] ar, input logic [31:0] ad, input bit is,
                       input logic [3:0] lr, input bit fl, input logic [31:0] ld,
                       input logic [3:0] r1, input logic [3:0] r2);
        bus.alu_wb_valid_i = av; bus.alu_wb_rd_i = ar; bus.alu_wb_data_i = ad;
        bus.load_issue_i = is; bus.load_rd_i = lr;
        bus.LSU_wb_flag_i = fl; bus.LSU_wb_data_i = ld;
        bus.rs1_addr_i = r1; bus.rs2_addr_i = r2;
    endtask
    function automatic logic [31:0] m_read(input logic [3:0] a, input bit w, input logic [3:0] wrd, input logic [31:0] wd);
        if (a == 4'd0) return 32'd0;
        if (BYP && w && wrd == a) return wd;
        return m_reg[a];
    endfunction
    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_reg[i] = 32'd0;
        m_pend = 0; m_err = 0; m_prd = 4'd0; m_wcnt = 0;
        skq.delete();
    endtask
    task automatic cyc();
        bit w, lsu, busy0, st;
        logic [3:0] wrd;
        logic [31:0] wd;
        ent_t e;
        @(negedge clk);
        lsu = m_pend && bus.LSU_wb_flag_i;
        busy0 = skq.size() != 0;
        w = 1'b1;
        if (lsu) begin wrd = m_prd; wd = bus.LSU_wb_data_i; end
        else if (busy0) begin wrd = skq[0].rd; wd = skq[0].d; end
        else if (bus.alu_wb_valid_i) begin wrd = bus.alu_wb_rd_i; wd = bus.alu_wb_data_i; end
        else begin w = 1'b0; wrd = 4'd0; wd = 32'd0; end
        st = (m_pend && m_prd != 0 && (bus.rs1_addr_i == m_prd || bus.rs2_addr_i == m_prd))
             || (!BYP && busy0 && (skq[0].rd == bus.rs1_addr_i || skq[0].rd == bus.rs2_addr_i));
        chk("rs1_data", bus.rs1_data_o, m_read(bus.rs1_addr_i, w, wrd, wd));
        chk("rs2_data", bus.rs2_data_o, m_read(bus.rs2_addr_i, w, wrd, wd));
        chk("stall", bus.load_use_stall_o, st);
        @(posedge clk);
        #1;
        if (bus.alu_wb_valid_i && busy0) m_err = 1;
        if (busy0 && !lsu) void'(skq.pop_front());
        if (lsu && bus.alu_wb_valid_i && !busy0 && bus.alu_wb_rd_i != m_prd) begin
            e.rd = bus.alu_wb_rd_i; e.d = bus.alu_wb_data_i;
            skq.push_back(e);
        end
        if (w && wrd != 0) m_reg[wrd] = wd;
        if (m_pend) begin
            if (bus.load_issue_i) m_err = 1;
            if (bus.LSU_wb_flag_i) m_pend = 0;
            else begin
                m_wcnt++;
                if (m_wcnt == LT) begin m_err = 1; m_pend = 0; end
            end
        end else begin
            if (bus.LSU_wb_flag_i) m_err = 1;
            if (bus.load_issue_i) begin m_pend = 1; m_prd = bus.load_rd_i; m_wcnt = 0; end
        end
        chk("commit_valid", bus.commit_valid_o, w);
        if (w) begin
            chk("commit_rd", bus.commit_rd_o, wrd);
            chk("commit_data", bus.commit_data_o, wrd == 0 ? 32'd0 : wd);
        end
        chk("err", bus.err_o, m_err);
        chk("busy", bus.wb_busy_o, skq.size() != 0);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 4'd1, 4'd15);
        m_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_commit_valid", bus.commit_valid_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_busy", bus.wb_busy_o, 0);
        chk("rst_stall", bus.load_use_stall_o, 0);
        chk("rst_rs1", bus.rs1_data_o, 0);
    endtask
    initial begin
        bit av, is, fl;
        logic [3:0] ar;
        do_reset();
        drv(1, 5, 32'h12345678, 0, 0, 0, 0, 0, 0); cyc();
        chk("t1_rd", bus.commit_rd_o, 5);
        chk("t1_data", bus.commit_data_o, 32'h12345678);
        drv(0, 0, 0, 0, 0, 0, 0, 5, 0); cyc();
        drv(0, 0, 0, 1, 3, 0, 0, 0, 3); cyc();
        drv(0, 0, 0, 0, 0, 1, 32'hFFFFFF80, 0, 3); cyc();
        chk("t2_data", bus.commit_data_o, 32'hFFFFFF80);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 3); cyc();
        drv(0, 0, 0, 1, 3, 0, 0, 0, 0); cyc();
        drv(1, 7, 32'hBB, 0, 0, 1, 32'hAA, 7, 3); cyc();
        chk("t3_first_rd", bus.commit_rd_o, 3);
        chk("t3_busy", bus.wb_busy_o, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 7, 3); cyc();
        chk("t3_second_rd", bus.commit_rd_o, 7);
        chk("t3_second_data", bus.commit_data_o, 32'hBB);
        drv(0, 0, 0, 1, 4, 0, 0, 0, 0); cyc();
        drv(1, 4, 32'h2, 0, 0, 1, 32'h1, 4, 0); cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 4, 4); cyc();
        chk("t4_single_commit", bus.commit_valid_o, 0);
        for (int i = 0; i < 400; i++) begin
            fl = m_pend && $urandom_range(0, 2) == 0;
            is = !m_pend && $urandom_range(0, 2) == 0;
            av = skq.size() == 0 && $urandom_range(0, 1) == 1;
            ar = $urandom_range(0, 3) == 0 ? m_prd : 4'($urandom_range(0, 15));
            drv(av, ar, $urandom, is, 4'($urandom_range(0, 15)), fl, $urandom,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            cyc();
        end
        do_reset();
        drv(1, 6, 32'h66, 0, 0, 0, 0, 0, 0); cyc();
        drv(0, 0, 0, 1, 6, 0, 0, 6, 0); cyc();
        for (int i = 0; i < LT; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 6, 6); cyc();
        end
        chk("timeout_err", bus.err_o, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 6, 0); cyc();
        drv(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0); cyc();
        chk("rd0_rd", bus.commit_rd_o, 0);
        chk("rd0_data", bus.commit_data_o, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
        do_reset();
        drv(0, 0, 0, 0, 0, 1, 32'h5, 0, 0); cyc();
        do_reset();
        drv(0, 0, 0, 1, 1, 0, 0, 0, 0); cyc();
        drv(0, 0, 0, 1, 2, 0, 0, 1, 2); cyc();
        drv(0, 0, 0, 0, 0, 1, 32'h11, 1, 2); cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 2); cyc();
        do_reset();
        drv(0, 0, 0, 1, 2, 0, 0, 0, 0); cyc();
        drv(1, 8, 32'h88, 0, 0, 1, 32'h22, 8, 2); cyc();
        drv(1, 9, 32'h99, 0, 0, 0, 0, 8, 9); cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 8, 9); cyc();
        drv(1, 5, 32'h55, 1, 9, 0, 0, 0, 0); cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 5, 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rs1", bus.rs1_data_o, 0);
        chk("async_stall", bus.load_use_stall_o, 0);
        chk("async_commit", bus.commit_valid_o, 0);
        chk("async_err", bus.err_o, 0);
        chk("async_busy", bus.wb_busy_o, 0);
        m_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drv(1, 2, 32'h2222, 0, 0, 0, 0, 2, 5); cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 2, 5); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_23060072_wbu.md
Name: ysyx_23060072_wbu

Overview:
- Write-back unit for the RV32E in-order pipeline. Sits directly downstream of the LSU and ALU.
- Owns the 16x32 integer register file, including its single write port and two read ports.
- The LSU result carries no destination register, so this block captures the load's rd at issue and tracks the single outstanding load.
- Arbitrates LSU and ALU write-back, forwards in-flight results to the read ports, raises the load-use stall, and emits a registered commit record.

Parameters:
- NREG, 16, number of architectural registers (RV32E).
- AW, 4, register address width; must equal log2(NREG).
- DW, 32, data width.
- LOAD_TIMEOUT, 15, maximum cycles in WAIT before the load is abandoned.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- alu_wb_valid_i  in  1  ALU result valid this cycle.
- alu_wb_rd_i  in  AW  ALU destination register.
- alu_wb_data_i  in  DW  ALU result.
- load_issue_i  in  1  a load is accepted by the LSU this cycle.
- load_rd_i  in  AW  destination register of the issuing load.
- LSU_wb_flag_i  in  1  load data valid (one-cycle pulse).
- LSU_wb_data_i  in  DW  extended load data.
- rs1_addr_i  in  AW  read port 1 address.
- rs2_addr_i  in  AW  read port 2 address.
- rs1_data_o  out  DW  read port 1 data (combinational).
- rs2_data_o  out  DW  read port 2 data (combinational).
- load_use_stall_o  out  1  a source register depends on the pending load.
- wb_busy_o  out  1  skid buffer occupied; upstream must not assert alu_wb_valid_i.
- commit_valid_o  out  1  registered: a register write happened last cycle.
- commit_rd_o  out  AW  registered: rd of that write.
- commit_data_o  out  DW  registered: data of that write.
- err_o  out  1  sticky protocol/timeout error.

Behaviour:
- Reset (asynchronous, rst_n low):
  - all registers 0, x0..x15 included;
  - FSM to IDLE; skid buffer empty; timeout counter 0;
  - err_o, commit_*_o, wb_busy_o all 0.
  - Any in-flight load or skid entry is dropped.
- Load tracker FSM:
  - IDLE, load_issue_i=1: capture load_rd_i, go to WAIT, clear the counter.
  - WAIT, LSU_wb_flag_i=1: write LSU_wb_data_i to the captured rd, go to IDLE.
  - WAIT, load_issue_i=1: ignored; set err_o.
  - IDLE, LSU_wb_flag_i=1: ignored; set err_o.
  - WAIT, counter reaches LOAD_TIMEOUT with no flag: set err_o, go to IDLE, no write.
  - The counter increments each WAIT cycle.
- Write-port priority (one write per cycle): LSU > skid > ALU.
  - ALU valid with no LSU write and skid empty: write directly.
  - ALU valid in the same cycle as an LSU write: ALU entry goes into the skid and is written the next cycle.
  - Same-rd collision: the ALU entry is discarded, because the ALU instruction is older and the load value must survive.
  - Skid drain takes priority over a new ALU write.
  - ALU valid while wb_busy_o=1: set err_o; the new entry is dropped.
- rd=0 writes:
  - never change x0;
  - still produce a commit record with data 0.
- Read ports:
  - address 0 returns 0;
  - otherwise forward the current-cycle write value when its rd matches the address, else the array value.
  - Forwarding precedence matches write priority (LSU > skid > ALU).
- load_use_stall_o is combinational. It is 1 when all three hold:
  - state is WAIT;
  - captured rd is non-zero;
  - rs1_addr_i or rs2_addr_i equals the captured rd.
- Commit record:
  - registered one cycle after each array write;
  - commit_valid_o pulses for one cycle per write;
  - at most one commit per cycle.
- Latency:
  - ALU result reaches the array at the clock edge of its valid cycle, or +1 if skidded;
  - load data reaches the array at the edge of the LSU_wb_flag_i cycle.

Optional Feature:
- Macro YSYX_23060072_WBU_BYPASS_EN.
- Defined: read-port forwarding as described above.
- Undefined:
  - read ports return array contents only;
  - load_use_stall_o additionally asserts in the LSU-write cycle when rs1 or rs2 matches the captured rd;
  - it also asserts whenever the skid is valid and its rd matches rs1 or rs2;
  - results become visible one cycle after the write.

Test Plan:
- Reset, then write x5=0x12345678 via ALU → next cycle rs1_addr=5 returns 0x12345678; commit_valid=1, rd=5, data=0x12345678.
- load_issue rd=3; next cycle LSU_wb_flag=1, data 0xFFFFFF80; rs2_addr=3 in the WAIT cycle → load_use_stall=1; after the flag x3=0xFFFFFF80, stall=0, FSM IDLE.
- Same cycle: LSU write x3=0xAA and ALU write x7=0xBB → x3 committed first, wb_busy=1 for one cycle, x7=0xBB committed next cycle, two commit pulses in order.
- Same cycle: LSU write x4=0x1 and ALU write x4=0x2 → x4=0x1, skid not loaded, single commit.
- load_issue rd=6 with no LSU flag for 16 cycles → err_o=1 at cycle 15, FSM IDLE, x6 unchanged.
- ALU write rd=0 data 0xDEAD → rs1_addr=0 reads 0; commit rd=0 data 0. Assert rst_n low mid-WAIT → all outputs 0 immediately.
